// File: rtl/sc_matrix_mult_accum.sv
// Batched stochastic matrix multiply: AND products, LFSR-selected mux add over the inner
// dimension, per-output ones counters, and a valid/ready result handoff.
module sc_matrix_mult_accum #(
   parameter int unsigned BATCH_SIZE      = 4,
   parameter int unsigned INPUT_FEATURES  = 4,
   parameter int unsigned OUTPUT_FEATURES = 4,
   parameter int unsigned STREAM_LENGTH   = 256,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   localparam int unsigned CNT_W          = $clog2(STREAM_LENGTH) + 1
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             start,
   output logic                                             busy,
   output logic                                             stream_req,
   input  logic [BATCH_SIZE*INPUT_FEATURES-1:0]             inputStreams,
   input  logic [OUTPUT_FEATURES*INPUT_FEATURES-1:0]        weightStreams,
   output logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]            outputStreams,
   output logic                                             stream_valid,
   output logic [BATCH_SIZE*OUTPUT_FEATURES*CNT_W-1:0]      outputCounts,
   output logic                                             result_valid,
   input  logic                                             result_ready
);

   localparam int unsigned N_CELL = BATCH_SIZE * OUTPUT_FEATURES;
   localparam int unsigned SEL_W  = $clog2(INPUT_FEATURES);
   localparam int unsigned RUN_W  = $clog2(STREAM_LENGTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [RUN_W-1:0]               run_cnt_q, run_cnt_d;
   logic [15:0]                    lfsr_q, lfsr_d;
   logic [N_CELL-1:0]              out_q, out_d;
   logic                           sv_q, sv_d;
   logic [N_CELL-1:0][CNT_W-1:0]   count_q, count_d;
   logic                           busy_q, busy_d;
   logic                           req_q, req_d;
   logic                           rv_q, rv_d;
   logic                           clear_c;
   logic [SEL_W-1:0]               sel_c;
   logic [N_CELL-1:0]              prod_c;

   assign sel_c = lfsr_q[SEL_W-1:0];

   // Per-output product: the same selected inner index feeds every (i,j) cell this cycle
   for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_row
      for (genvar gj = 0; gj < OUTPUT_FEATURES; gj++) begin : g_col
         logic [INPUT_FEATURES-1:0] a_row;
         logic [INPUT_FEATURES-1:0] b_row;
         assign a_row = inputStreams[gi*INPUT_FEATURES +: INPUT_FEATURES];
         assign b_row = weightStreams[gj*INPUT_FEATURES +: INPUT_FEATURES];
         assign prod_c[gi*OUTPUT_FEATURES+gj] = a_row[sel_c] & b_row[sel_c];
      end
   end

   for (genvar gk = 0; gk < N_CELL; gk++) begin : g_cnt
      assign count_d[gk] = clear_c ? '0 :
                           (sv_q ? count_q[gk] + CNT_W'(out_q[gk]) : count_q[gk]);
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      lfsr_d    = lfsr_q;
      out_d     = out_q;
      sv_d      = sv_q;
      clear_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               clear_c = 1'b1;
            end
         end
         S_RUN: begin
            out_d     = prod_c;
            sv_d      = 1'b1;
            lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            run_cnt_d = run_cnt_q + RUN_W'(1);
            if (run_cnt_q == RUN_W'(STREAM_LENGTH - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            sv_d    = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (result_ready) begin
               if (start) begin
                  state_d = S_RUN;
                  clear_c = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (clear_c) begin
         run_cnt_d = '0;
         lfsr_d    = LFSR_SEED;
      end

      busy_d = (state_d != S_IDLE);
      req_d  = (state_d == S_RUN);
      rv_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         run_cnt_q <= '0;
         lfsr_q    <= LFSR_SEED;
         out_q     <= '0;
         sv_q      <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         req_q     <= 1'b0;
         rv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         lfsr_q    <= lfsr_d;
         out_q     <= out_d;
         sv_q      <= sv_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         req_q     <= req_d;
         rv_q      <= rv_d;
      end
   end

   assign busy          = busy_q;
   assign stream_req    = req_q;
   assign result_valid  = rv_q;
   assign outputStreams = out_q;
   assign stream_valid  = sv_q;
   assign outputCounts  = count_q;

endmodule

// File: tb/tb_sc_matrix_mult_accum.sv
// Directed self-checking bench for sc_matrix_mult_accum with default parameters.
module tb_sc_matrix_mult_accum;

   localparam int M     = 4;
   localparam int N     = 4;
   localparam int O     = 4;
   localparam int L     = 256;
   localparam int CNT_W = 9;
   localparam int NC    = M * O;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  busy;
   logic                  stream_req;
   logic [M*N-1:0]        input_streams;
   logic [O*N-1:0]        weight_streams;
   logic [NC-1:0]         output_streams;
   logic                  stream_valid;
   logic [NC*CNT_W-1:0]   counts;
   logic                  result_valid;
   logic                  result_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sc_matrix_mult_accum dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .busy          (busy),
      .stream_req    (stream_req),
      .inputStreams  (input_streams),
      .weightStreams (weight_streams),
      .outputStreams (output_streams),
      .stream_valid  (stream_valid),
      .outputCounts  (counts),
      .result_valid  (result_valid),
      .result_ready  (result_ready)
   );

   function automatic int get_cnt(input int k);
      logic [NC*CNT_W-1:0] v;
      v = counts >> (k * CNT_W);
      return int'(v[CNT_W-1:0]);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_run;
      repeat (L + 1) step();
   endtask

   task automatic release_result;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (busy !== 1'b0 || stream_req !== 1'b0 || result_valid !== 1'b0 || stream_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b req=%b rv=%b sv=%b required all 0", busy, stream_req, result_valid, stream_valid);
      end
      checks++;
      if (counts !== '0 || output_streams !== '0) begin
         errors++;
         $display("FAIL reset_data: counts=%h streams=%h required 0", counts, output_streams);
      end
   endtask

   task automatic test_all_ones;
      input_streams  = '1;
      weight_streams = '1;
      pulse_start();
      checks++;
      if (stream_req !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL ones_run_entry: req=%b busy=%b rv=%b required 1 1 0", stream_req, busy, result_valid);
      end
      step();
      checks++;
      if (stream_valid !== 1'b1 || output_streams !== '1) begin
         errors++;
         $display("FAIL ones_first_bit: sv=%b streams=%h required 1 ffff", stream_valid, output_streams);
      end
      repeat (L - 1) step();
      checks++;
      if (stream_req !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ones_drain: req=%b rv=%b busy=%b required 0 0 1", stream_req, result_valid, busy);
      end
      step();
      checks++;
      if (result_valid !== 1'b1 || stream_valid !== 1'b0) begin
         errors++;
         $display("FAIL ones_done: rv=%b sv=%b required 1 0", result_valid, stream_valid);
      end
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (get_cnt(k) != 256) begin
            errors++;
            $display("FAIL ones_count[%0d]: got %0d required 256", k, get_cnt(k));
         end
      end
      release_result();
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ones_handoff: rv=%b busy=%b required 0 0", result_valid, busy);
      end
   endtask

   task automatic test_all_zero;
      int n;
      input_streams  = '0;
      weight_streams = '1;
      n = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < L + 4; c++) begin
         if (stream_req === 1'b1) n++;
         step();
      end
      checks++;
      if (n != L) begin
         errors++;
         $display("FAIL zero_req_cycles: got %0d required %0d", n, L);
      end
      checks++;
      if (result_valid !== 1'b1 || counts !== '0) begin
         errors++;
         $display("FAIL zero_counts: rv=%b counts=%h required 1 and 0", result_valid, counts);
      end
      release_result();
   endtask

   task automatic test_single;
      input_streams  = 16'h0001;
      weight_streams = 16'h0001;
      pulse_start();
      wait_run();
      checks++;
      if (get_cnt(0) < 48 || get_cnt(0) > 80) begin
         errors++;
         $display("FAIL single_count00: got %0d required 48..80", get_cnt(0));
      end
      for (int k = 1; k < NC; k++) begin
         checks++;
         if (get_cnt(k) != 0) begin
            errors++;
            $display("FAIL single_count[%0d]: got %0d required 0", k, get_cnt(k));
         end
      end
      release_result();
   endtask

   task automatic test_hold;
      int bad;
      input_streams  = '1;
      weight_streams = '1;
      pulse_start();
      wait_run();
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         start = c[0];
         step();
         if (result_valid !== 1'b1 || stream_req !== 1'b0 || busy !== 1'b1) bad++;
         for (int k = 0; k < NC; k++) if (get_cnt(k) != 256) bad++;
      end
      start = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_stable: %0d deviations in 20 cycles, required 0", bad);
      end
      release_result();
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: busy=%b rv=%b required 0 0", busy, result_valid);
      end
   endtask

   task automatic test_reset_midrun;
      input_streams  = '1;
      weight_streams = '1;
      pulse_start();
      repeat (100) step();
      checks++;
      if (stream_req !== 1'b1) begin
         errors++;
         $display("FAIL midrun_running: req=%b required 1", stream_req);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || stream_req !== 1'b0 || result_valid !== 1'b0 || stream_valid !== 1'b0 || counts !== '0) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b req=%b rv=%b sv=%b counts=%h required all 0", busy, stream_req, result_valid, stream_valid, counts);
      end
      step();
      checks++;
      if (busy !== 1'b0 || stream_req !== 1'b0) begin
         errors++;
         $display("FAIL midrun_idle: busy=%b req=%b required 0 0", busy, stream_req);
      end
      pulse_start();
      wait_run();
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (get_cnt(k) != 256 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_rerun[%0d]: got %0d rv=%b required 256 rv=1", k, get_cnt(k), result_valid);
         end
      end
      release_result();
   endtask

   task automatic test_back_to_back;
      int first;
      input_streams  = '1;
      weight_streams = '1;
      pulse_start();
      wait_run();
      result_ready = 1'b1;
      start = 1'b1;
      step();
      result_ready = 1'b0;
      start = 1'b0;
      checks++;
      if (stream_req !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0 || counts !== '0) begin
         errors++;
         $display("FAIL b2b_restart: req=%b busy=%b rv=%b counts=%h required 1 1 0 0", stream_req, busy, result_valid, counts);
      end
      wait_run();
      for (int k = 0; k < NC; k++) begin
         checks++;
         if (get_cnt(k) != 256) begin
            errors++;
            $display("FAIL b2b_count[%0d]: got %0d required 256", k, get_cnt(k));
         end
      end
      input_streams  = 16'h0001;
      weight_streams = 16'h0001;
      result_ready = 1'b1;
      start = 1'b1;
      step();
      result_ready = 1'b0;
      start = 1'b0;
      wait_run();
      first = get_cnt(0);
      checks++;
      if (first < 48 || first > 80) begin
         errors++;
         $display("FAIL b2b_single_first: got %0d required 48..80", first);
      end
      result_ready = 1'b1;
      start = 1'b1;
      step();
      result_ready = 1'b0;
      start = 1'b0;
      wait_run();
      checks++;
      if (get_cnt(0) != first || result_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_repeat: got %0d rv=%b required %0d rv=1", get_cnt(0), result_valid, first);
      end
      release_result();
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      result_ready   = 1'b0;
      input_streams  = '0;
      weight_streams = '0;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_all_ones();
      test_all_zero();
      test_single();
      test_hold();
      test_reset_midrun();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
